// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// elaboration-time legality checks for the multiplier depth and divider radix.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    function automatic bit mul_stages_legal(input int stages);
        return (stages >= 1) && (stages <= 4);
    endfunction

    function automatic bit div_radix_legal(input int width, input int radix_bits);
        return ((radix_bits == 1) || (radix_bits == 2)) && ((width % radix_bits) == 0);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes, RADIX_BITS quotient bits
// per cycle. The first step is taken on the start edge so valid pulses after WIDTH/RADIX_BITS edges.
module mdu_divider #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);
    localparam int STEPS = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic               busy;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   dsr_p0;
    logic [2*WIDTH-1:0] rq_p0;
    logic [2*WIDTH-1:0] rq_nxt;

    // {remainder, quotient} advanced by RADIX_BITS shift/compare/subtract steps
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] rq,
                                                    input logic [WIDTH-1:0]   d);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] q;
        r = {1'b0, rq[2*WIDTH-1:WIDTH]};
        q = rq[WIDTH-1:0];
        for (int i = 0; i < RADIX_BITS; i++) begin
            r = {r[WIDTH-1:0], q[WIDTH-1]};
            q = {q[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, d}) begin
                r    = r - {1'b0, d};
                q[0] = 1'b1;
            end
        end
        return {r[WIDTH-1:0], q};
    endfunction

    assign rq_nxt = div_step(start ? {{WIDTH{1'b0}}, dividend} : rq_p0,
                             start ? divisor : dsr_p0);

    always_ff @(posedge clk) begin
        if (start) begin
            dsr_p0 <= divisor;
        end
        if (start || busy) begin
            rq_p0 <= rq_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy  <= 1'b0;
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (annul) begin
                busy <= 1'b0;
            end else if (start) begin
                busy <= 1'b1;
                cnt  <= CNT_W'(STEPS - 1);
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

    assign quotient  = rq_p0[WIDTH-1:0];
    assign remainder = rq_p0[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mul_div_unit.sv
// MIPS32 multiply/divide unit owning HI/LO: pipelined multiplier, iterative divider.
// Define MDU_MADD_EN to enable MADD/MSUB (ops 6/7) accumulating into {HI,LO}.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int MUL_STAGES     = 2,
    parameter int DIV_RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    if (!mul_stages_legal(MUL_STAGES)) begin : g_bad_mul
        $error("MUL_STAGES must be in 1..4");
    end
    if (!div_radix_legal(WIDTH, DIV_RADIX_BITS)) begin : g_bad_div
        $error("DIV_RADIX_BITS must be 1 or 2 and divide WIDTH");
    end

    mdu_state_e         state, state_nxt;
    logic               accept, busy, is_mul, is_div, is_mac;
    logic               mul_start, div_start, done_nxt, dz_nxt;
    logic               hi_we, lo_we;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;
    logic [2:0]         mul_cnt;
    logic               q_neg, r_neg;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    assign busy   = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    assign accept = start_i && ((state == ST_IDLE) || (state == ST_DONE));
    assign is_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
`ifdef MDU_MADD_EN
    assign is_mac = (op_i == OP_MADD) || (op_i == OP_MSUB);
`else
    assign is_mac = 1'b0;
`endif
    assign stall_o = (accept && (is_mul || is_div || is_mac)) || busy;

    // Multiplier: operands sign/zero-extended to 2*WIDTH so one signed product serves both
    logic                      mul_signed;
    logic signed [2*WIDTH-1:0] mul_a_p0, mul_b_p0, mul_prod;
    logic        [2*WIDTH-1:0] mul_res;

    assign mul_signed = (op_i != OP_MULTU);

    always_ff @(posedge clk) begin
        if (mul_start) begin
            mul_a_p0 <= {{WIDTH{mul_signed & src1_i[WIDTH-1]}}, src1_i};
            mul_b_p0 <= {{WIDTH{mul_signed & src2_i[WIDTH-1]}}, src2_i};
        end
    end

    assign mul_prod = mul_a_p0 * mul_b_p0;

    if (MUL_STAGES == 1) begin : g_mul_comb
        assign mul_res = mul_prod;
    end else begin : g_mul_pipe
        logic [2*WIDTH-1:0] pipe_p1 [MUL_STAGES-1];
        always_ff @(posedge clk) begin
            pipe_p1[0] <= mul_prod;
            for (int k = 1; k < MUL_STAGES - 1; k++) begin
                pipe_p1[k] <= pipe_p1[k-1];
            end
        end
        assign mul_res = pipe_p1[MUL_STAGES-2];
    end

    // Divider: magnitudes in, signs reapplied in FIX
    logic             div_signed, div_valid;
    logic [WIDTH-1:0] div_a_mag, div_b_mag, div_quo, div_rem;

    assign div_signed = (op_i == OP_DIV);
    assign div_a_mag  = (div_signed && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    assign div_b_mag  = (div_signed && src2_i[WIDTH-1]) ? -src2_i : src2_i;

    mdu_divider #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (DIV_RADIX_BITS)
    ) u_divider (
        .clk       (clk),
        .rstn      (rstn),
        .start     (div_start),
        .annul     (annul_i && (state == ST_DIV)),
        .dividend  (div_a_mag),
        .divisor   (div_b_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

`ifdef MDU_MADD_EN
    logic               mac_p0, mac_sub_p0;
    logic [2*WIDTH-1:0] mac_prod_p2, mac_acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mac_p0     <= 1'b0;
            mac_sub_p0 <= 1'b0;
        end else if (mul_start || div_start) begin
            mac_p0     <= is_mac;
            mac_sub_p0 <= (op_i == OP_MSUB);
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_MUL) begin
            mac_prod_p2 <= mul_res;
        end
    end

    assign mac_acc = mac_sub_p0 ? ({hi_o, lo_o} - mac_prod_p2) : ({hi_o, lo_o} + mac_prod_p2);
`endif

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        div_start = 1'b0;
        done_nxt  = 1'b0;
        dz_nxt    = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_nxt    = hi_o;
        lo_nxt    = lo_o;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (is_mul || is_mac) begin
                        state_nxt = ST_MUL;
                        mul_start = 1'b1;
                    end else if (is_div) begin
                        if (src2_i == '0) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                            dz_nxt    = 1'b1;
                        end else begin
                            state_nxt = ST_DIV;
                            div_start = 1'b1;
                        end
                    end else if (op_i == OP_MTHI) begin
                        hi_we  = 1'b1;
                        hi_nxt = src1_i;
                    end else if (op_i == OP_MTLO) begin
                        lo_we  = 1'b1;
                        lo_nxt = src1_i;
                    end
                end
            end
            ST_MUL: begin
                if (annul_i) begin
                    state_nxt = ST_IDLE;
                end else if (mul_cnt == 3'(MUL_STAGES)) begin
`ifdef MDU_MADD_EN
                    if (mac_p0) begin
                        state_nxt = ST_FIX;
                    end else begin
`else
                    begin
`endif
                        {hi_nxt, lo_nxt} = mul_res;
                        hi_we     = 1'b1;
                        lo_we     = 1'b1;
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_DIV: begin
                if (annul_i) begin
                    state_nxt = ST_IDLE;
                end else if (div_valid) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                if (annul_i) begin
                    state_nxt = ST_IDLE;
                end else begin
                    hi_we     = 1'b1;
                    lo_we     = 1'b1;
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
`ifdef MDU_MADD_EN
                    if (mac_p0) begin
                        {hi_nxt, lo_nxt} = mac_acc;
                    end else begin
`else
                    begin
`endif
                        hi_nxt = apply_sign(div_rem, r_neg);
                        lo_nxt = apply_sign(div_quo, q_neg);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            done_o     <= 1'b0;
            div_zero_o <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            mul_cnt    <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            state      <= state_nxt;
            done_o     <= done_nxt;
            div_zero_o <= dz_nxt;
            if (hi_we) begin
                hi_o <= hi_nxt;
            end
            if (lo_we) begin
                lo_o <= lo_nxt;
            end
            if (mul_start) begin
                mul_cnt <= 3'd1;
            end else if (state == ST_MUL) begin
                mul_cnt <= mul_cnt + 3'd1;
            end
            if (div_start) begin
                q_neg <= div_signed & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                r_neg <= div_signed & src1_i[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO/div_zero and completion cycle
// are queued at issue and checked whenever done_o pulses.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, start_i, annul_i;
    logic [2:0]  op_i;
    logic [31:0] src1_i, src2_i;
    logic        stall_o, done_o, div_zero_o;
    logic [31:0] hi_o, lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    mul_div_unit dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .op_i       (op_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .annul_i    (annul_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn && div_zero_o) check("dz_without_done", 64'(done_o), 64'd1);
        if (rstn && done_o) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done_o), 64'd0);
            end else begin
                e = sb.pop_front();
                check("done_hi", 64'(hi_o), 64'(e.hi));
                check("done_lo", 64'(lo_o), 64'(e.lo));
                check("done_div_zero", 64'(div_zero_o), 64'(e.dz));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic expect_res(input logic [31:0] hi, input logic [31:0] lo,
                              input logic dz, input int lat);
        sb.push_back('{hi, lo, dz, cyc + lat});
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall, input string tag);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        #1;
        check({tag, "_stall"}, 64'(stall_o), 64'(exp_stall));
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            step();
            n++;
        end
        check({tag, "_pending"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start_i = 1'b0; annul_i = 1'b0;
        op_i = 3'd0; src1_i = '0; src2_i = '0;
        step();
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_dz", 64'(div_zero_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        step();
        rstn = 1'b1;
        idle(1);

        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 3);
        issue(OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b1, "mult");
        wait_idle(10, "mult");

        expect_res(32'h2, 32'hFFFF_FFFA, 1'b0, 3);
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'h3, 1'b1, "multu");
        wait_idle(10, "multu");

        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1, "div_neg7");
        for (int n = 1; n <= 34; n++) begin
            #1;
            check($sformatf("div_stall_c%0d", n), 64'(stall_o), 64'(n <= 33));
            step();
        end
        wait_idle(5, "div_neg7");

        expect_res(32'h1, 32'h3, 1'b0, 34);
        issue(OP_DIVU, 32'h7, 32'h2, 1'b1, "divu");
        wait_idle(40, "divu");

        issue(OP_MTHI, 32'h11, 32'h0, 1'b0, "mthi");
        issue(OP_MTLO, 32'h22, 32'h0, 1'b0, "mtlo");
        check("mt_hi", 64'(hi_o), 64'h11);
        check("mt_lo", 64'(lo_o), 64'h22);

        expect_res(32'h11, 32'h22, 1'b1, 1);
        issue(OP_DIV, 32'h5, 32'h0, 1'b1, "div_zero");
        wait_idle(5, "div_zero");
        check("div_zero_hi_kept", 64'(hi_o), 64'h11);

        expect_res(32'h0, 32'h8000_0000, 1'b0, 34);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
        wait_idle(40, "div_ovf");

        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, "divu_annul");
        idle(9);
        annul_i = 1'b1;
        step();
        annul_i = 1'b0;
        #1;
        check("annul_stall", 64'(stall_o), 64'd0);
        idle(40);
        check("annul_hi", 64'(hi_o), 64'h0);
        check("annul_lo", 64'(lo_o), 64'h8000_0000);

        expect_res(32'h0, 32'd30, 1'b0, 3);
        issue(OP_MULTU, 32'd5, 32'd6, 1'b1, "b2b_first");
        idle(2);
        check("b2b_in_done", 64'(done_o), 64'd1);
        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 3);
        issue(OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b1, "b2b_second");
        wait_idle(10, "b2b");

        issue(OP_DIV, 32'd100, 32'd7, 1'b1, "div_rst");
        idle(4);
        rstn = 1'b0;
        #1;
        check("midrst_hi", 64'(hi_o), 64'h0);
        check("midrst_lo", 64'(lo_o), 64'h0);
        check("midrst_stall", 64'(stall_o), 64'd0);
        step();
        rstn = 1'b1;
        idle(40);

`ifdef MDU_MADD_EN
        issue(OP_MTHI, 32'h0, 32'h0, 1'b0, "madd_mthi");
        issue(OP_MTLO, 32'h5, 32'h0, 1'b0, "madd_mtlo");
        expect_res(32'h0, 32'h11, 1'b0, 4);
        issue(OP_MADD, 32'd3, 32'd4, 1'b1, "madd");
        wait_idle(10, "madd");
        expect_res(32'h0, 32'h5, 1'b0, 4);
        issue(OP_MSUB, 32'd3, 32'd4, 1'b1, "msub");
        wait_idle(10, "msub");
`else
        issue(OP_MTLO, 32'h5, 32'h0, 1'b0, "nop_mtlo");
        issue(3'd6, 32'd3, 32'd4, 1'b0, "op6_nop");
        #1;
        check("op6_no_busy", 64'(stall_o), 64'd0);
        idle(6);
        check("op6_lo_kept", 64'(lo_o), 64'h5);
        check("op6_hi_kept", 64'(hi_o), 64'h0);
`endif

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair. Replaces the ad-hoc HI/LO, multiply and divide logic in the execute stage.
- Sits beside the ALU in execute. Accepts one operation per start pulse and stalls the pipeline while busy. Exposes HI/LO for MFHI/MFLO.
- Supports a pipelined multiplier of configurable depth and an iterative divider of configurable radix. Results follow MIPS32 semantics.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
MUL_STAGES, 2, multiplier pipeline depth in cycles (1..4)
DIV_RADIX_BITS, 1, quotient bits resolved per divide cycle (1 or 2; WIDTH divisible by it)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start_i  in  1  operation request; sampled on the rising edge of clk
op_i  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (see Optional Feature)
src1_i  in  WIDTH  rs operand (dividend, multiplicand, MTHI/MTLO data)
src2_i  in  WIDTH  rt operand (divisor, multiplier)
annul_i  in  1  abort the in-flight multiply/divide
stall_o  out  1  pipeline stall request
done_o  out  1  one-cycle pulse: HI/LO now hold the new result
div_zero_o  out  1  one-cycle pulse with done_o when the divisor was zero
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- Reset: all outputs, HI, LO and internal state go to 0; state = IDLE. Reset mid-operation discards that operation; no done_o follows.
- States: IDLE, MUL, DIV, FIX, DONE. start_i is accepted only in IDLE or DONE; it is ignored in MUL, DIV and FIX.
- MTHI/MTLO: HI or LO is written with src1_i at the accepting edge. No state change, no done_o, no stall.
- MULT/MULTU: operands are captured at the accepting edge (cycle 0) and the unit enters MUL.
  - After MUL_STAGES cycles, {HI,LO} is written with the 2*WIDTH product and the unit enters DONE.
  - done_o is high in cycle MUL_STAGES+1.
  - MULT is signed two's complement; MULTU is unsigned.
- DIV/DIVU, divisor nonzero:
  - Magnitudes are captured and the unit enters DIV for WIDTH/DIV_RADIX_BITS cycles of restoring division.
  - It then spends one FIX cycle applying signs, then enters DONE.
  - With default parameters, done_o is high in cycle 34.
  - LO = quotient, HI = remainder.
  - Signed: quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - Overflow case: most-negative / -1 gives LO = 0x80000000, HI = 0 (wrap, no trap).
- DIV/DIVU, divisor zero: HI/LO unchanged. DONE is entered next cycle with done_o = div_zero_o = 1.
- stall_o:
  - = start_i & (op is MULT/MULTU/DIV/DIVU) & state in {IDLE, DONE}, combinationally,
  - OR state in {MUL, DIV, FIX}.
  - It is low in DONE so the stalled instruction retires.
- DONE always lasts one cycle. The next state is IDLE, or the new operation if start_i is accepted.
- annul_i in MUL, DIV or FIX: return to IDLE next edge with HI/LO unchanged and no done_o. annul_i in IDLE or DONE is ignored. If annul_i and start_i are high in the same cycle, annul_i wins.
- HI/LO are written only at the edges stated above. hi_o/lo_o are register outputs with no bypass.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 6 = MADD (signed), op 7 = MSUB (signed). They take the MULT path plus one accumulate cycle.
  - {HI,LO} <= {HI,LO} ± product, modulo 2^(2*WIDTH).
  - done_o is high in cycle MUL_STAGES+2.
- Undefined: ops 6/7 are treated as no-ops, with no state change, no stall and no done_o.

Decomposition:
- Package mdu_pkg holds the op_i encodings, state encoding, and the MUL_STAGES and DIV_RADIX_BITS legality checks.
- Sub-module mdu_divider holds the iterative magnitude divider core: start, magnitudes in, quotient/remainder out, valid pulse, annul.
- Sign handling, the multiplier pipeline and HI/LO stay in mul_div_unit.

Test Plan:
- MULT src1=0xFFFFFFFE, src2=0x00000003 -> done_o in cycle 3; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV src1=0xFFFFFFF9 (-7), src2=2 -> stall_o high cycles 0..33; done_o in cycle 34; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- DIV with src2=0 after MTHI 0x11, MTLO 0x22 -> done_o and div_zero_o in cycle 1; HI=0x11, LO=0x22.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU started, annul_i at cycle 10 -> IDLE at cycle 11, no done_o, HI/LO unchanged. A MULT issued the same cycle the unit is in DONE is accepted and completes normally.
- rstn low during DIV -> hi_o=lo_o=0 immediately, stall_o=0, no done_o afterwards. With MDU_MADD_EN: HI=0, LO=5, MADD 3*4 -> LO=0x11 in cycle 4.
